neuron_state_updater: RTL and testbench
=======================================

Name: neuron_state_updater

Overview:
- Per-timestep sweep engine that sits directly upstream of the neuron-state single-port RAM (registered read address, one-cycle read latency, write on `write_enable`).
- For every neuron it does a read-modify-write of the membrane potential: V' = V + I − LEAK, then threshold compare and reset.
- Spikes are emitted on a valid/ready stream towards the router interface.
- Synaptic current I comes from an external accumulator memory with the same one-cycle read latency.

Parameters:
- DATA_WIDTH, 16, width of potential and current words (two's complement signed).
- ADDRESS_WIDTH, 8, RAM address width.
- NUM_NEURONS, 256, neurons swept per step; 1 ≤ NUM_NEURONS ≤ 2^ADDRESS_WIDTH.
- THRESHOLD, 1000, signed firing threshold.
- LEAK, 1, signed constant subtracted each step.
- RESET_POTENTIAL, 0, signed value written after a spike.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last neuron is written.
- ram_addr  out  ADDRESS_WIDTH  address to the state RAM.
- ram_write_enable  out  1  RAM write strobe.
- ram_data_in  out  DATA_WIDTH  write data to the RAM.
- ram_data_out  in  DATA_WIDTH  RAM read data; valid the cycle after the address is presented.
- cur_addr  out  ADDRESS_WIDTH  current-memory address; always equals ram_addr.
- cur_data  in  DATA_WIDTH  synaptic current; same one-cycle latency as the RAM.
- spike_valid  out  1  spike pending.
- spike_id  out  ADDRESS_WIDTH  index of the spiking neuron.
- spike_ready  in  1  downstream accepts; transfer occurs when valid && ready.
- spike_count  out  ADDRESS_WIDTH+1  spikes in the current/last sweep; cleared on accepted start.

Behaviour:
- Reset values: busy=0, done=0, ram_write_enable=0, spike_valid=0, spike_count=0, ram_addr=0, ram_data_in=0, spike_id=0; state IDLE; neuron index idx=0.
- A reset mid-sweep aborts immediately. No write is issued in the reset cycle. Neurons already written keep their new values.
- States:
  - IDLE: on start, idx←0, spike_count←0, go READ.
  - READ: ram_addr=idx, ram_write_enable=0; go UPDATE.
  - UPDATE: ram_data_out and cur_data are valid.
    - Compute sum = V + I − LEAK at DATA_WIDTH+2 bits, then saturate to the signed DATA_WIDTH range.
    - If sum ≥ THRESHOLD: fire=1, v_reg←RESET_POTENTIAL. Else v_reg←saturated sum.
    - Register fire; go WRITE.
  - WRITE: ram_addr=idx, ram_write_enable=1, ram_data_in=v_reg.
    - If fire: spike_valid=1, spike_id=idx.
    - Leave WRITE only when !fire or spike_ready. On leaving, spike_count increments if fire.
    - Then: if idx==NUM_NEURONS−1 go DONE, else idx←idx+1 and go READ.
  - DONE: done=1 for one cycle, busy=0 next cycle; go IDLE.
- Backpressure: while stalled in WRITE, the same v_reg is rewritten each cycle, which is idempotent. The RAM read-back is never reused, so there is no double leak. spike_valid, spike_id and ram outputs stay stable until the handshake.
- Throughput: 3 cycles per neuron without stalls.
- Latency: start pulse at cycle 0 → done at cycle 3·NUM_NEURONS+1.
- ram_write_enable is asserted only in WRITE; ram_addr is never 0-padded beyond NUM_NEURONS−1.
- start is ignored in every state except IDLE, including the DONE cycle.
- Saturation: the maximum positive current cannot wrap negative, and the maximum negative sum clamps to −2^(DATA_WIDTH−1).

Test Plan:
- NUM_NEURONS=4, V=0, I=10 for all, LEAK=1, THRESHOLD=1000, start → RAM holds 9,9,9,9; spike_count=0; done exactly 13 cycles after start.
- Neuron 2 V=995, I=10 → spike_valid with spike_id=2; RAM[2]=RESET_POTENTIAL=0; spike_count=1.
- Same as the previous scenario with spike_ready held low for 5 cycles → WRITE holds 5 extra cycles; RAM[2]=0 (not −1); exactly one spike transfer; done 5 cycles later.
- V=32767, I=32767 → RAM=32767 when THRESHOLD is set above the range (parameter 32767 case: spike). V=−32768, I=−32768 → RAM=−32768.
- Assert rst during the WRITE of neuron 1 → outputs return to reset values the next cycle; RAM[0] updated, RAM[1] unchanged; a new start runs a full sweep.
- start pulses while busy and during DONE → ignored; only one done pulse; spike_count is not cleared.

Source files
------------

// File: rtl/neuron_state_updater.sv
// Sweeps every neuron once per timestep: read V and I, compute V + I - LEAK with
// saturation, fire and reset on threshold, write back, and stream spike ids out.
module neuron_state_updater #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int NUM_NEURONS     = 256,
  parameter int THRESHOLD       = 1000,
  parameter int LEAK            = 1,
  parameter int RESET_POTENTIAL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_write_enable,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic [ADDRESS_WIDTH-1:0] cur_addr,
  input  logic [DATA_WIDTH-1:0]    cur_data,
  output logic                     spike_valid,
  output logic [ADDRESS_WIDTH-1:0] spike_id,
  input  logic                     spike_ready,
  output logic [ADDRESS_WIDTH:0]   spike_count
);

  typedef enum logic [2:0] {IDLE, READ, UPDATE, WRITE, DONE} state_t;

  localparam int SUM_WIDTH = DATA_WIDTH + 2;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NUM_NEURONS - 1);
  localparam logic signed [SUM_WIDTH-1:0] MAX_VALUE = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] MIN_VALUE = {3'b111, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_WIDTH-1:0] LEAK_EXT = SUM_WIDTH'(LEAK);
  localparam logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(RESET_POTENTIAL);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic                     fire_q;
  logic                     write_q;

  logic signed [SUM_WIDTH-1:0]  sum;
  logic signed [DATA_WIDTH-1:0] sat;
  logic signed [31:0]           sat_wide;
  logic                         fire;

  // Two guard bits keep V + I - LEAK exact before clamping to the word range.
  always_comb begin
    sum      = SUM_WIDTH'($signed(ram_data_out)) + SUM_WIDTH'($signed(cur_data)) - LEAK_EXT;
    sat      = sum[DATA_WIDTH-1:0];
    if (sum > MAX_VALUE)
      sat = MAX_VALUE[DATA_WIDTH-1:0];
    else if (sum < MIN_VALUE)
      sat = MIN_VALUE[DATA_WIDTH-1:0];
    sat_wide = 32'(sat);
    fire     = (sat_wide >= THRESHOLD);
  end

  // Write strobe is masked by reset so an aborted sweep never writes in the reset cycle.
  assign ram_write_enable = write_q & ~rst;
  assign cur_addr         = ram_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      fire_q      <= 1'b0;
      write_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_count <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      spike_id    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx         <= '0;
            ram_addr    <= '0;
            spike_count <= '0;
            busy        <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          state <= UPDATE;
        end
        UPDATE: begin
          ram_data_in <= fire ? RESET_VALUE : sat;
          fire_q      <= fire;
          write_q     <= 1'b1;
          spike_valid <= fire;
          spike_id    <= idx;
          state       <= WRITE;
        end
        // A stalled spike simply rewrites the same value; the read-back is never reused.
        WRITE: begin
          if (!fire_q || spike_ready) begin
            write_q     <= 1'b0;
            spike_valid <= 1'b0;
            if (fire_q)
              spike_count <= spike_count + 1'b1;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx      <= idx + 1'b1;
              ram_addr <= idx + 1'b1;
              state    <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_state_updater.sv
// Directed bench: four-neuron sweep with behavioural state/current RAMs, plus a
// two-neuron instance with an out-of-range threshold to observe saturation directly.
module tb_neuron_state_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  cur_addr;
  logic [15:0] cur_data;
  logic        spike_valid;
  logic [7:0]  spike_id;
  logic        spike_ready;
  logic [8:0]  spike_count;

  logic        s_start;
  logic        s_busy;
  logic        s_done;
  logic [7:0]  s_ram_addr;
  logic        s_ram_we;
  logic [15:0] s_ram_din;
  logic [15:0] s_ram_dout;
  logic [7:0]  s_cur_addr;
  logic [15:0] s_cur_data;
  logic        s_spike_valid;
  logic [7:0]  s_spike_id;
  logic [8:0]  s_spike_count;

  logic [15:0] mem     [0:3];
  logic [15:0] cur_mem [0:3];
  logic [15:0] smem    [0:1];
  logic [15:0] scur    [0:1];
  logic        load_en = 1'b0;
  logic        s_load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [15:0] load_data = 16'd0;

  int checks = 0;
  int errors = 0;
  int transfers = 0;
  int done_pulses = 0;
  logic [7:0] last_id = 8'd0;

  neuron_state_updater #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_NEURONS(4),
    .THRESHOLD(1000), .LEAK(1), .RESET_POTENTIAL(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_write_enable(ram_we), .ram_data_in(ram_din),
    .ram_data_out(ram_dout), .cur_addr(cur_addr), .cur_data(cur_data),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
    .spike_count(spike_count)
  );

  neuron_state_updater #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_NEURONS(2),
    .THRESHOLD(40000), .LEAK(1), .RESET_POTENTIAL(0)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .ram_addr(s_ram_addr), .ram_write_enable(s_ram_we), .ram_data_in(s_ram_din),
    .ram_data_out(s_ram_dout), .cur_addr(s_cur_addr), .cur_data(s_cur_data),
    .spike_valid(s_spike_valid), .spike_id(s_spike_id), .spike_ready(1'b1),
    .spike_count(s_spike_count)
  );

  always #5 clk = ~clk;

  // Registered-address RAMs with one-cycle read latency; the load port preloads state.
  always @(posedge clk) begin
    if (load_en) mem[load_addr[1:0]] <= load_data;
    else if (ram_we) mem[ram_addr[1:0]] <= ram_din;
    ram_dout <= mem[ram_addr[1:0]];
    cur_data <= cur_mem[cur_addr[1:0]];
    if (s_load_en) smem[load_addr[0]] <= load_data;
    else if (s_ram_we) smem[s_ram_addr[0]] <= s_ram_din;
    s_ram_dout <= smem[s_ram_addr[0]];
    s_cur_data <= scur[s_cur_addr[0]];
  end

  always @(posedge clk) begin
    if (spike_valid && spike_ready) begin
      transfers <= transfers + 1;
      last_id   <= spike_id;
    end
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic load_word(input logic sat_dut, input int n, input logic [15:0] v, input logic [15:0] i);
    @(negedge clk);
    load_addr = 8'(n);
    load_data = v;
    if (sat_dut) begin
      s_load_en = 1'b1;
      scur[n]   = i;
    end else begin
      load_en    = 1'b1;
      cur_mem[n] = i;
    end
    @(negedge clk);
    load_en   = 1'b0;
    s_load_en = 1'b0;
  endtask

  // Starts a sweep and returns the cycle count to done; optionally stalls the spike
  // of exp_id for a number of cycles and pokes start while busy.
  task automatic run_sweep(input int stall, input int exp_id, input logic poke,
                           output int cycles, output logic stable_ok);
    int stalled;
    stalled   = 0;
    stable_ok = 1'b1;
    cycles    = 0;
    @(negedge clk);
    start = 1'b1;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      start = poke && (cycles == 5);
      if (spike_valid && !spike_ready) begin
        if (spike_id !== 8'(exp_id) || ram_addr !== 8'(exp_id) || ram_din !== 16'd0 || ram_we !== 1'b1)
          stable_ok = 1'b0;
        if (stalled == stall) spike_ready = 1'b1;
        else stalled++;
      end
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || spike_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: busy=%b done=%b we=%b valid=%b expected all 0", busy, done, ram_we, spike_valid);
    end
    checks++;
    if (spike_count !== 9'd0 || ram_addr !== 8'd0 || ram_din !== 16'd0 || spike_id !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: count=%0d addr=%0d din=%0d id=%0d expected all 0", spike_count, ram_addr, ram_din, spike_id);
    end
  endtask

  task automatic test_basic;
    int cyc;
    int tr0;
    logic ok;
    for (int n = 0; n < 4; n++) load_word(1'b0, n, 16'd0, 16'd10);
    tr0 = transfers;
    run_sweep(0, 0, 1'b0, cyc, ok);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected 13", cyc);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mem[n] !== 16'd9) begin
        errors++;
        $display("[TB] FAIL basic_ram[%0d]: got %0d expected 9", n, $signed(mem[n]));
      end
    end
    @(negedge clk);
    checks++;
    if (spike_count !== 9'd0 || transfers != tr0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_no_spike: count=%0d transfers=%0d busy=%b expected 0 0 0", spike_count, transfers - tr0, busy);
    end
  endtask

  task automatic test_spike(input int stall);
    int cyc;
    int tr0;
    logic ok;
    logic [15:0] exp_mem [0:3];
    exp_mem[0] = 16'd9; exp_mem[1] = 16'd9; exp_mem[2] = 16'd0; exp_mem[3] = 16'd9;
    for (int n = 0; n < 4; n++) load_word(1'b0, n, (n == 2) ? 16'd995 : 16'd0, 16'd10);
    tr0 = transfers;
    if (stall > 0) spike_ready = 1'b0;
    run_sweep(stall, 2, 1'b0, cyc, ok);
    checks++;
    if (cyc !== 13 + stall) begin
      errors++;
      $display("[TB] FAIL spike_latency_stall%0d: got %0d cycles expected %0d", stall, cyc, 13 + stall);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mem[n] !== exp_mem[n]) begin
        errors++;
        $display("[TB] FAIL spike_ram[%0d]_stall%0d: got %0d expected %0d", n, stall, $signed(mem[n]), $signed(exp_mem[n]));
      end
    end
    checks++;
    if (spike_count !== 9'd1 || transfers - tr0 != 1 || last_id !== 8'd2) begin
      errors++;
      $display("[TB] FAIL spike_stream_stall%0d: count=%0d transfers=%0d id=%0d expected 1 1 2", stall, spike_count, transfers - tr0, last_id);
    end
    if (stall > 0) begin
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("[TB] FAIL backpressure_stable: got %b expected 1", ok);
      end
    end
    spike_ready = 1'b1;
  endtask

  task automatic test_saturation;
    int cyc;
    int tr0;
    logic ok;
    logic valid_seen;
    logic [15:0] exp_mem [0:3];
    exp_mem[0] = 16'd0; exp_mem[1] = 16'h8000; exp_mem[2] = 16'd0; exp_mem[3] = 16'd999;
    load_word(1'b0, 0, 16'h7FFF, 16'h7FFF);
    load_word(1'b0, 1, 16'h8000, 16'h8000);
    load_word(1'b0, 2, 16'd999, 16'd2);
    load_word(1'b0, 3, 16'd1000, 16'd0);
    tr0 = transfers;
    run_sweep(0, 0, 1'b0, cyc, ok);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mem[n] !== exp_mem[n]) begin
        errors++;
        $display("[TB] FAIL sat_ram[%0d]: got %0d expected %0d", n, $signed(mem[n]), $signed(exp_mem[n]));
      end
    end
    checks++;
    if (spike_count !== 9'd2 || transfers - tr0 != 2) begin
      errors++;
      $display("[TB] FAIL sat_spikes: count=%0d transfers=%0d expected 2 2", spike_count, transfers - tr0);
    end
    // Threshold above the word range: a clamped maximum must be stored, not fire.
    load_word(1'b1, 0, 16'h7FFF, 16'h7FFF);
    load_word(1'b1, 1, 16'h8000, 16'h8000);
    valid_seen = 1'b0;
    cyc = 0;
    @(negedge clk);
    s_start = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      s_start = 1'b0;
      cyc++;
      if (s_spike_valid) valid_seen = 1'b1;
      if (s_done) break;
    end
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("[TB] FAIL sat_dut_latency: got %0d expected 7", cyc);
    end
    checks++;
    if (smem[0] !== 16'h7FFF || smem[1] !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL sat_dut_ram: got %0d %0d expected 32767 -32768", $signed(smem[0]), $signed(smem[1]));
    end
    @(negedge clk);
    checks++;
    if (valid_seen !== 1'b0 || s_spike_count !== 9'd0 || s_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_dut_no_spike: valid=%b count=%0d busy=%b expected 0 0 0", valid_seen, s_spike_count, s_busy);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int cyc;
    logic ok;
    logic [15:0] exp_mem [0:3];
    exp_mem[0] = 16'd18; exp_mem[1] = 16'd9; exp_mem[2] = 16'd9; exp_mem[3] = 16'd9;
    for (int n = 0; n < 4; n++) load_word(1'b0, n, 16'd0, 16'd10);
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (ram_we && ram_addr == 8'd1) break;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || spike_valid !== 1'b0 || ram_addr !== 8'd0 || ram_din !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy=%b we=%b valid=%b addr=%0d din=%0d expected all 0", busy, ram_we, spike_valid, ram_addr, ram_din);
    end
    rst = 1'b0;
    checks++;
    if (mem[0] !== 16'd9 || mem[1] !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midreset_ram: got %0d %0d expected 9 0", $signed(mem[0]), $signed(mem[1]));
    end
    run_sweep(0, 0, 1'b0, cyc, ok);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("[TB] FAIL midreset_rerun_latency: got %0d expected 13", cyc);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mem[n] !== exp_mem[n]) begin
        errors++;
        $display("[TB] FAIL midreset_rerun_ram[%0d]: got %0d expected %0d", n, $signed(mem[n]), $signed(exp_mem[n]));
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int dp0;
    logic ok;
    logic busy_seen;
    for (int n = 0; n < 4; n++) load_word(1'b0, n, (n == 2) ? 16'd995 : 16'd0, 16'd10);
    dp0 = done_pulses;
    run_sweep(0, 2, 1'b1, cyc, ok);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("[TB] FAIL ignore_latency: got %0d expected 13", cyc);
    end
    checks++;
    if (busy_seen !== 1'b0 || done_pulses - dp0 != 1) begin
      errors++;
      $display("[TB] FAIL ignore_restart: busy_seen=%b done_pulses=%0d expected 0 1", busy_seen, done_pulses - dp0);
    end
    checks++;
    if (spike_count !== 9'd1) begin
      errors++;
      $display("[TB] FAIL ignore_count: got %0d expected 1", spike_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    s_start     = 1'b0;
    spike_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      mem[n]     = 16'd0;
      cur_mem[n] = 16'd0;
    end
    for (int n = 0; n < 2; n++) begin
      smem[n] = 16'd0;
      scur[n] = 16'd0;
    end
    test_reset();
    test_basic();
    test_spike(0);
    test_spike(5);
    test_saturation();
    test_reset_mid_sweep();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
